// File: rtl/hash_test_pkg.sv
// Shared definitions for the hash test runner: FSM state encoding, the
// expected-hash word count helper and the UUT reset hold length.
package hash_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_MSG = 3'd1,
        ST_LOAD_EXP = 3'd2,
        ST_UUT_RST  = 3'd3,
        ST_RUN      = 3'd4,
        ST_CHECK    = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam int unsigned UUT_RST_CYCLES = 2;

    // Number of stream words needed to carry an n-bit digest.
    function automatic int unsigned hash_words(input int unsigned n, input int unsigned dw);
        return (n + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/exp_hash_loader.sv
// Expected-digest collector: shifts in stream words, first word ending up most
// significant, and flags when a full digest has been received.
//   clk, rst_n  : clock, async active-low reset
//   clr         : empties the collector (held while a message word is awaited)
//   load_en     : shift word in this cycle
//   word        : incoming stream word
//   exp_words   : collected words, first received word in the top slot
//   full        : all words collected
//   fill_c      : this cycle's load completes the digest
module exp_hash_loader
    import hash_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned N          = 256
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         clr,
    input  logic                                         load_en,
    input  logic [DATA_WIDTH-1:0]                        word,
    output logic [hash_words(N, DATA_WIDTH)*DATA_WIDTH-1:0] exp_words,
    output logic                                         full,
    output logic                                         fill_c
);

    localparam int unsigned HW = hash_words(N, DATA_WIDTH);
    localparam int unsigned SW = HW * DATA_WIDTH;
    localparam int unsigned CW = $clog2(HW + 1);

    logic [CW-1:0] cnt;
    logic [SW-1:0] sr_shift;

    if (HW == 1) begin : g_one
        assign sr_shift = word;
    end else begin : g_multi
        assign sr_shift = {exp_words[SW-DATA_WIDTH-1:0], word};
    end

    assign fill_c = load_en && !full && (cnt == CW'(HW - 1));

    // Shift register and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_words <= '0;
            cnt       <= '0;
            full      <= 1'b0;
        end else if (clr) begin
            exp_words <= '0;
            cnt       <= '0;
            full      <= 1'b0;
        end else if (load_en && !full) begin
            exp_words <= sr_shift;
            cnt       <= cnt + 1'b1;
            full      <= (cnt == CW'(HW - 1));
        end
    end

endmodule

// File: rtl/hash_test_runner.sv
// Streams test vectors into a hash UUT, times each run, compares digests and
// keeps pass/fail/timeout statistics.
//   clk, rst              : clock, async active-low reset
//   start, num_vectors    : run request and vector count (sampled on start)
//   vec_data/valid/ready  : vector word stream (message word, then digest words)
//   rst_uut, msg_uut      : UUT hold-in-reset and message word
//   end_uut, hash_o_uut   : UUT completion flag and digest
//   busy, done            : run in progress / run finished (sticky)
//   pass_cnt, fail_cnt, tmo_cnt, first_fail_idx, last_latency, debug : results
module hash_test_runner
    import hash_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned N              = 256,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_vectors,
    input  logic [DATA_WIDTH-1:0] vec_data,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    output logic                  rst_uut,
    output logic [DATA_WIDTH-1:0] msg_uut,
    input  logic                  end_uut,
    input  logic [N-1:0]          hash_o_uut,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [CNT_W-1:0]      tmo_cnt,
    output logic [CNT_W-1:0]      first_fail_idx,
    output logic [31:0]           last_latency,
    output logic [31:0]           debug
);

    localparam int unsigned HW  = hash_words(N, DATA_WIDTH);
    localparam int unsigned RCW = $clog2(UUT_RST_CYCLES + 1);

    state_e                   state, state_nxt;
    logic [CNT_W-1:0]         idx, idx_nxt, nv, nv_nxt;
    logic [CNT_W-1:0]         pass_nxt, fail_nxt, tmo_nxt, ffi_nxt;
    logic                     fail_seen, seen_nxt;
    logic                     timed_out, tmo_flag_nxt;
    logic [31:0]              lat, lat_nxt, last_lat_nxt;
    logic [N-1:0]             hash_q, hash_nxt;
    logic [RCW-1:0]           rcnt, rcnt_nxt;
    logic [DATA_WIDTH-1:0]    msg_nxt;
    logic                     done_nxt;
    logic                     xfer_c, hash_match_c;
    logic [HW*DATA_WIDTH-1:0] exp_words;
    logic                     exp_full, exp_fill_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign xfer_c       = vec_valid && vec_ready;
    assign hash_match_c = (hash_q == exp_words[N-1:0]);

    exp_hash_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N)
    ) u_loader (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (state == ST_LOAD_MSG),
        .load_en   (xfer_c && (state == ST_LOAD_EXP)),
        .word      (vec_data),
        .exp_words (exp_words),
        .full      (exp_full),
        .fill_c    (exp_fill_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        nv_nxt       = nv;
        pass_nxt     = pass_cnt;
        fail_nxt     = fail_cnt;
        tmo_nxt      = tmo_cnt;
        ffi_nxt      = first_fail_idx;
        seen_nxt     = fail_seen;
        tmo_flag_nxt = timed_out;
        lat_nxt      = lat;
        last_lat_nxt = last_latency;
        hash_nxt     = hash_q;
        rcnt_nxt     = rcnt;
        msg_nxt      = msg_uut;
        done_nxt     = done;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pass_nxt     = '0;
                    fail_nxt     = '0;
                    tmo_nxt      = '0;
                    ffi_nxt      = '1;
                    seen_nxt     = 1'b0;
                    idx_nxt      = '0;
                    last_lat_nxt = '0;
                    nv_nxt       = num_vectors;
                    if (num_vectors == '0) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_LOAD_MSG;
                        done_nxt  = 1'b0;
                    end
                end
            end
            ST_LOAD_MSG: begin
                if (xfer_c) begin
                    msg_nxt   = vec_data;
                    state_nxt = ST_LOAD_EXP;
                end
            end
            ST_LOAD_EXP: begin
                if (exp_full || exp_fill_c) begin
                    rcnt_nxt  = '0;
                    state_nxt = ST_UUT_RST;
                end
            end
            ST_UUT_RST: begin
                if (rcnt == RCW'(UUT_RST_CYCLES - 1)) begin
                    lat_nxt   = 32'd1;
                    state_nxt = ST_RUN;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            ST_RUN: begin
                // Completion beats a coincident timeout.
                if (end_uut) begin
                    hash_nxt     = hash_o_uut;
                    last_lat_nxt = lat;
                    tmo_flag_nxt = 1'b0;
                    state_nxt    = ST_CHECK;
                end else if (lat >= 32'(TIMEOUT_CYCLES)) begin
                    tmo_nxt      = sat_inc(tmo_cnt);
                    fail_nxt     = sat_inc(fail_cnt);
                    tmo_flag_nxt = 1'b1;
                    state_nxt    = ST_CHECK;
                end else begin
                    lat_nxt = lat + 32'd1;
                end
            end
            ST_CHECK: begin
                if (!timed_out) begin
                    if (hash_match_c) pass_nxt = sat_inc(pass_cnt);
                    else              fail_nxt = sat_inc(fail_cnt);
                end
                if ((timed_out || !hash_match_c) && !fail_seen) begin
                    ffi_nxt  = idx;
                    seen_nxt = 1'b1;
                end
                idx_nxt = idx + 1'b1;
                if ((CNT_W + 1)'(idx) + 1'b1 == (CNT_W + 1)'(nv)) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_LOAD_MSG;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; decoded outputs follow the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            nv             <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            tmo_cnt        <= '0;
            first_fail_idx <= '1;
            fail_seen      <= 1'b0;
            timed_out      <= 1'b0;
            lat            <= '0;
            last_latency   <= '0;
            hash_q         <= '0;
            rcnt           <= '0;
            msg_uut        <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            vec_ready      <= 1'b0;
            rst_uut        <= 1'b1;
            debug          <= '0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            nv             <= nv_nxt;
            pass_cnt       <= pass_nxt;
            fail_cnt       <= fail_nxt;
            tmo_cnt        <= tmo_nxt;
            first_fail_idx <= ffi_nxt;
            fail_seen      <= seen_nxt;
            timed_out      <= tmo_flag_nxt;
            lat            <= lat_nxt;
            last_latency   <= last_lat_nxt;
            hash_q         <= hash_nxt;
            rcnt           <= rcnt_nxt;
            msg_uut        <= msg_nxt;
            done           <= done_nxt;
            busy           <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            vec_ready      <= (state_nxt == ST_LOAD_MSG) || (state_nxt == ST_LOAD_EXP);
            rst_uut        <= (state_nxt != ST_RUN) && (state_nxt != ST_CHECK);
            debug          <= {16'(fail_nxt), 16'(pass_nxt)};
        end
    end

endmodule

// File: doc/hash_test_runner.md
HASH_TEST_RUNNER -- requirements
Module: hash_test_runner

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of the vector stream words and of the UUT message word.
REQ-002 Parameter N, default 256, UUT hash output width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, maximum cycles allowed from UUT reset release to end_uut.
REQ-004 Parameter CNT_W, default 16, width of the vector, pass, fail and timeout counters.
REQ-005 Port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, one-cycle pulse that starts a run; ignored unless in IDLE or DONE.
REQ-008 Port num_vectors, input, CNT_W, number of vectors to run; sampled on start.
REQ-009 Port vec_data / vec_valid / vec_ready, input DATA_WIDTH / input 1 / output 1, vector word stream; a word transfers when valid and ready are both high.
REQ-010 Port rst_uut, output, 1, active-high hold-in-reset to the hash UUT.
REQ-011 Port msg_uut, output, DATA_WIDTH, message word to the UUT.
REQ-012 Port end_uut, input, 1, UUT completion flag.
REQ-013 Port hash_o_uut, input, N, UUT digest.
REQ-014 Ports busy and done, output, 1 each; done is sticky until the next accepted start.
REQ-015 Ports pass_cnt, fail_cnt and tmo_cnt, output, CNT_W each; first_fail_idx, output, CNT_W; last_latency, output, 32.
REQ-016 Port debug, output, 32, equal to {fail_cnt[15:0], pass_cnt[15:0]}, zero-extended when CNT_W < 16.

Function
REQ-017 HW = ceil(N/DATA_WIDTH). Each vector is 1 message word followed by HW expected-hash words, most-significant word first; the low N bits of the concatenation are the expected hash.
REQ-018 States: IDLE, LOAD_MSG, LOAD_EXP, UUT_RST, RUN, CHECK, DONE.
REQ-019 IDLE/DONE -> LOAD_MSG on start: clear all counters; set first_fail_idx to all-ones; set vector index to 0. If num_vectors = 0, go directly to DONE with done = 1.
REQ-020 vec_ready is high only in LOAD_MSG and LOAD_EXP.
- LOAD_MSG: the accepted word is registered to msg_uut; go to LOAD_EXP.
- LOAD_EXP: accept exactly HW words, then go to UUT_RST.
REQ-021 rst_uut is high in every state except RUN and CHECK.
- UUT_RST lasts exactly 2 cycles, then goes to RUN.
REQ-022 RUN: a 32-bit latency counter starts at 1 on the first RUN cycle.
- end_uut = 1: register hash_o_uut and the latency counter into last_latency; go to CHECK.
- Latency counter reaches TIMEOUT_CYCLES without end_uut: increment tmo_cnt and fail_cnt; go to CHECK with the compare forced to fail.
REQ-023 CHECK lasts 1 cycle.
- Match: increment pass_cnt.
- Mismatch (not a timeout): increment fail_cnt.
- On the first failure of the run, first_fail_idx = vector index.
- Then increment the index: if index = num_vectors go to DONE, otherwise go to LOAD_MSG.
REQ-024 Counters saturate at all-ones and never wrap.
REQ-025 busy = 1 in every state except IDLE and DONE.
REQ-026 start while busy is ignored; num_vectors changes while busy are ignored.
REQ-027 If end_uut and the timeout condition occur in the same cycle, end_uut wins: the vector is compared normally.
REQ-028 An end_uut seen outside RUN is ignored.
REQ-029 Stream stalls (vec_valid low) are unbounded and do not advance the timeout counter.

Reset
REQ-030 Asynchronous assertion of rst forces all registers to their reset values; release is synchronous to clk.
REQ-031 Reset values:
- state IDLE, busy 0, done 0, vec_ready 0, rst_uut 1, msg_uut 0.
- All counters 0, first_fail_idx all-ones, last_latency 0.
REQ-032 Reset mid-run abandons the run; no partial results are retained.

Structure
REQ-033 Shared package hash_test_pkg holds:
- the state enum type;
- a function computing HW from N and DATA_WIDTH;
- the UUT_RST_CYCLES = 2 constant.
REQ-034 One sub-module, exp_hash_loader: shift register of HW*DATA_WIDTH bits with a load-enable and a word counter; it asserts full after HW words and is cleared on each LOAD_MSG entry.

Verification
REQ-035 DATA_WIDTH=64, N=256, num_vectors=3, stub UUT with latency 140 and correct digests -> pass_cnt=3, fail_cnt=0, last_latency=140, done=1, debug=32'h0000_0003.
REQ-036 Same setup, vector 1 expected hash with bit 0 flipped -> pass_cnt=2, fail_cnt=1, first_fail_idx=1.
REQ-037 Stub never asserts end_uut, TIMEOUT_CYCLES=200, num_vectors=2 -> tmo_cnt=2, fail_cnt=2, first_fail_idx=0, each RUN lasting exactly 200 cycles.
REQ-038 vec_valid toggled randomly with 30% idle cycles -> same results as REQ-035, and no word transfers while vec_ready is low.
REQ-039 rst pulsed low during RUN of vector 1 -> all outputs return to reset values immediately; a subsequent start with num_vectors=1 gives pass_cnt=1.
REQ-040 num_vectors=0 -> done=1 within 1 cycle of start, rst_uut stays 1, no vec_ready assertion.
